// File: rtl/sata_err_reg.sv
// Per-port SATA error-injection request register: eight independent four-phase
// request/acknowledge handshakes toward the PHY-side error injector.
module sata_err_reg (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       phyclk,
    input  logic       err_we,
    input  logic [7:0] err_wdata,
    input  logic [7:0] err_ack,
    output logic [7:0] err_req,
    output logic [7:0] err_sts
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT_ACK_LOW = 2'd2
    } hs_state_e;

    logic [7:0] ack_s1_q;
    logic [7:0] ack_s2_q;
    logic [7:0] req_q;
    logic [7:0] req_d;

    // phyclk only exists for interface compatibility; nothing is clocked by it.
    logic unused_phyclk;
    assign unused_phyclk = phyclk;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack_s1_q <= 8'h00;
            ack_s2_q <= 8'h00;
            req_q    <= 8'h00;
        end else begin
            ack_s1_q <= err_ack;
            ack_s2_q <= ack_s1_q;
            req_q    <= req_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            hs_state_e state;
            logic      req_bit_d;

            // The handshake phase is fully implied by req and the synchronized
            // ack, so it is decoded rather than stored; a bit becomes writable
            // in the very cycle its status drops.
            always_comb begin
                state     = ST_IDLE;
                req_bit_d = 1'b0;
                if (req_q[gi]) begin
                    state = ST_REQ;
                end else if (ack_s2_q[gi]) begin
                    state = ST_WAIT_ACK_LOW;
                end
                case (state)
                    ST_IDLE:         req_bit_d = err_we & err_wdata[gi];
                    ST_REQ:          req_bit_d = ~ack_s2_q[gi];
                    ST_WAIT_ACK_LOW: req_bit_d = 1'b0;
                    default:         req_bit_d = 1'b0;
                endcase
            end

            assign req_d[gi] = req_bit_d;
        end
    endgenerate

    assign err_req = req_q;
    assign err_sts = req_q | ack_s2_q;

endmodule

// File: tb/tb_sata_err_reg.sv
// Self-checking bench for sata_err_reg: directed vector table, hand-written
// reset sequences and randomized traffic against a behavioural model.
module tb_sata_err_reg;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       phyclk = 1'b0;
    logic       err_we;
    logic [7:0] err_wdata;
    logic [7:0] err_ack;
    logic [7:0] err_req;
    logic [7:0] err_sts;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;
    always #7 phyclk  = ~phyclk;

    sata_err_reg dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .phyclk    (phyclk),
        .err_we    (err_we),
        .err_wdata (err_wdata),
        .err_ack   (err_ack),
        .err_req   (err_req),
        .err_sts   (err_sts)
    );

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic [7:0] ack;
        logic [7:0] exp_req;
        logic [7:0] exp_sts;
    } vec_t;

    vec_t tbl[25];

    // Behavioural model: ack history as a delay line (the PHY ack is seen two
    // edges late), plus one pending-request flag per error type.
    logic [7:0] ack_hist[$];
    bit         m_req[8];

    function automatic logic [7:0] m_seen_ack();
        return (ack_hist.size() >= 2) ? ack_hist[ack_hist.size() - 2] : 8'h00;
    endfunction

    function automatic logic [7:0] m_req_vec();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = m_req[i];
        return v;
    endfunction

    task automatic m_reset();
        ack_hist.delete();
        for (int i = 0; i < 8; i++) m_req[i] = 0;
    endtask

    task automatic m_edge(input logic we, input logic [7:0] wd, input logic [7:0] ack);
        logic [7:0] seen;
        seen = m_seen_ack();
        for (int i = 0; i < 8; i++) begin
            if (m_req[i]) begin
                if (seen[i]) m_req[i] = 0;
            end else if (!seen[i] && we && wd[i]) begin
                m_req[i] = 1;
            end
        end
        ack_hist.push_back(ack);
        if (ack_hist.size() > 2) void'(ack_hist.pop_front());
    endtask

    task automatic check(input string name, input logic [7:0] exp_req, input logic [7:0] exp_sts);
        n_checks += 2;
        if (err_req !== exp_req) begin
            n_fail++;
            $display("FAIL %s err_req: got %02h expected %02h", name, err_req, exp_req);
        end
        if (err_sts !== exp_sts) begin
            n_fail++;
            $display("FAIL %s err_sts: got %02h expected %02h", name, err_sts, exp_sts);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst) m_reset();
        else m_edge(err_we, err_wdata, err_ack);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic [7:0] ack,
                                input logic [7:0] er, input logic [7:0] es);
        vec_t v;
        v.we = we; v.wd = wd; v.ack = ack; v.exp_req = er; v.exp_sts = es;
        return v;
    endfunction

    initial begin
        logic [7:0] ack_cur;
        logic [31:0] r;

        tbl[0]  = mk(1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5);
        tbl[1]  = mk(1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5);
        tbl[2]  = mk(1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5);
        tbl[3]  = mk(1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF);
        tbl[4]  = mk(1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF);
        tbl[5]  = mk(1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        tbl[6]  = mk(1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF);
        tbl[7]  = mk(1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF);
        tbl[8]  = mk(1'b1, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        tbl[9]  = mk(1'b0, 8'h00, 8'h00, 8'h00, 8'hFF);
        tbl[10] = mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[11] = mk(1'b1, 8'h01, 8'h00, 8'h01, 8'h01);
        tbl[12] = mk(1'b0, 8'h00, 8'h01, 8'h01, 8'h01);
        tbl[13] = mk(1'b0, 8'h00, 8'h01, 8'h01, 8'h01);
        tbl[14] = mk(1'b0, 8'h00, 8'h01, 8'h00, 8'h01);
        tbl[15] = mk(1'b1, 8'h01, 8'h01, 8'h00, 8'h01);
        tbl[16] = mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h01);
        tbl[17] = mk(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        tbl[18] = mk(1'b1, 8'h0F, 8'h00, 8'h0F, 8'h0F);
        tbl[19] = mk(1'b0, 8'h00, 8'h04, 8'h0F, 8'h0F);
        tbl[20] = mk(1'b0, 8'h00, 8'h04, 8'h0F, 8'h0F);
        tbl[21] = mk(1'b0, 8'h00, 8'h04, 8'h0B, 8'h0F);
        tbl[22] = mk(1'b0, 8'h00, 8'h00, 8'h0B, 8'h0F);
        tbl[23] = mk(1'b0, 8'h00, 8'h00, 8'h0B, 8'h0B);
        tbl[24] = mk(1'b1, 8'h0F, 8'h00, 8'h0F, 8'h0F);

        sys_rst   = 1'b1;
        err_we    = 1'b0;
        err_wdata = 8'h00;
        err_ack   = 8'hFF;
        m_reset();

        // Reset with the PHY ack stuck high: idle during reset, busy 2 edges after.
        tick();
        check("in_reset_a", 8'h00, 8'h00);
        tick();
        check("in_reset_b", 8'h00, 8'h00);
        $display("reset held: req=%02h sts=%02h", err_req, err_sts);
        sys_rst = 1'b0;
        tick();
        check("post_reset_1", 8'h00, 8'h00);
        tick();
        check("post_reset_2", 8'h00, 8'hFF);
        $display("reset released: req=%02h sts=%02h", err_req, err_sts);
        err_ack = 8'h00;
        tick();
        tick();
        check("ack_drop_after_reset", 8'h00, 8'h00);

        for (int i = 0; i < 25; i++) begin
            err_we    = tbl[i].we;
            err_wdata = tbl[i].wd;
            err_ack   = tbl[i].ack;
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_sts);
            $display("vec %0d: we=%0b wd=%02h ack=%02h -> req=%02h sts=%02h",
                     i, tbl[i].we, tbl[i].wd, tbl[i].ack, err_req, err_sts);
        end
        err_we = 1'b0;

        // Reset mid-handshake must clear without a clock edge.
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_reset_no_edge", 8'h00, 8'h00);
        $display("async reset: req=%02h sts=%02h", err_req, err_sts);
        m_reset();
        tick();
        sys_rst = 1'b0;
        tick();
        check("after_async_reset", 8'h00, 8'h00);

        ack_cur = 8'h00;
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            ack_cur   = ack_cur ^ (r[7:0] & r[15:8] & r[23:16]);
            err_ack   = ack_cur;
            err_we    = r[24] & r[25];
            err_wdata = 8'($urandom);
            tick();
            check($sformatf("rand%0d", n), m_req_vec(), m_req_vec() | m_seen_ack());
            $display("rand %0d: we=%0b wd=%02h ack=%02h -> req=%02h sts=%02h",
                     n, err_we, err_wdata, err_ack, err_req, err_sts);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
